ahb_master_arb: RTL and testbench
=================================

AHB_MASTER_ARB -- requirements
Module: ahb_master_arb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning HADDR and request address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning HWDATA, HRDATA and request data width.
REQ-003 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst; the ports are clk (input, 1 bit, clock) and rst (input, 1 bit, async active-low reset).
REQ-004 The block SHALL have the port f_req_valid (input, 1 bit): fetch read request.
REQ-005 The block SHALL have the port f_req_addr (input, ADDR_W bits): fetch address.
REQ-006 The block SHALL have the port f_req_ready (output, 1 bit): fetch request accepted this cycle.
REQ-007 The block SHALL have the ports f_rsp_valid (output, 1 bit), f_rsp_rdata (output, DATA_W bits) and f_rsp_err (output, 1 bit): fetch response.
REQ-008 The block SHALL have the ports d_req_valid (input, 1 bit), d_req_addr (input, ADDR_W bits), d_req_write (input, 1 bit) and d_req_wdata (input, DATA_W bits): load/store request.
REQ-009 The block SHALL have the ports d_req_ready (output, 1 bit), d_rsp_valid (output, 1 bit), d_rsp_rdata (output, DATA_W bits) and d_rsp_err (output, 1 bit): data-side handshake and response.
REQ-010 The block SHALL have the AHB-Lite master ports HADDR (output, ADDR_W bits), HTRANS (output, 2 bits), HWRITE (output, 1 bit), HWDATA (output, DATA_W bits), HRDATA (input, DATA_W bits), HREADY (input, 1 bit) and HRESP (input, 1 bit).
REQ-011 The block SHALL have the port bus_busy (output, 1 bit): state is not IDLE.

Function
REQ-012 The block SHALL implement the FSM states IDLE, ADDR and DATA, with one outstanding transfer and no pipelined overlap.
REQ-013 In IDLE, if any request is valid, the block SHALL register the grant, latch addr, write and wdata, and go to ADDR on the next edge.
REQ-014 In ADDR, the block SHALL drive HTRANS=NONSEQ (2'b10) with HADDR and HWRITE from the latched values; when HREADY=1, it SHALL go to DATA.
REQ-015 In ADDR, the block SHALL hold all address-phase signals stable while HREADY=0.
REQ-016 In DATA, the block SHALL drive HTRANS=IDLE (2'b00) and HWDATA=latched wdata for writes (0 for reads); the block SHALL wait while HREADY=0.
REQ-017 In DATA with HREADY=1, the block SHALL pulse the granted requester's rsp_valid for exactly 1 cycle, with rsp_rdata=HRDATA for reads (0 for writes), rsp_err=HRESP, and return to IDLE.
REQ-018 The block SHALL drive HTRANS=IDLE in every state except ADDR, including during a two-cycle HRESP error response.
REQ-019 The block SHALL pulse req_ready for 1 cycle in the IDLE cycle in which the request is granted; the requester SHALL hold valid and its payload until ready.
REQ-020 Arbitration SHALL be two-way round-robin: if both requesters are valid in IDLE, the block SHALL grant the requester not granted last; a single valid requester SHALL always win.
REQ-021 The fetch port SHALL always issue HWRITE=0.
REQ-022 Minimum latency SHALL be: request in IDLE at cycle N, NONSEQ at N+1, rsp_valid at N+2 with zero wait states.
REQ-023 Request inputs SHALL be ignored outside IDLE.
REQ-024 A requester dropping valid before ready SHALL NOT cause a bus transfer.

Reset
REQ-025 Asserting rst (low) at any time SHALL asynchronously force: state=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, all ready/rsp outputs 0, bus_busy=0, last_grant=fetch.
REQ-026 A transfer in progress at reset SHALL be abandoned and produce no response.
REQ-027 The first simultaneous request after reset SHALL be granted to the data port.

Structure
REQ-028 A shared package ahb_pkg SHALL hold the htrans_t encodings (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11) and the bus FSM state enum.
REQ-029 Round-robin grant logic SHALL be the sub-module rr_arb2 (req[1:0], last register, grant one-hot).

Verification
REQ-030 The bench SHALL cover: d_req write addr=0x100 wdata=0xDEADBEEF, HREADY=1 -> NONSEQ/HWRITE=1/HADDR=0x100 at N+1, HWDATA=0xDEADBEEF and d_rsp_valid at N+2.
REQ-031 The bench SHALL cover: f_req addr=0x40, HREADY low 3 cycles in DATA, HRDATA=0x00000013 -> f_rsp_valid once, rdata=0x13, after 3 wait cycles.
REQ-032 The bench SHALL cover: both ports request continuously from reset -> grant order data, fetch, data, fetch.
REQ-033 The bench SHALL cover: HRESP=1,HREADY=0 then HRESP=1,HREADY=1 on a data read -> d_rsp_err=1 with d_rsp_valid, HTRANS=IDLE throughout.
REQ-034 The bench SHALL cover: rst low during DATA with HREADY=0 -> outputs zero immediately, no rsp_valid, the next request starts a clean NONSEQ.
REQ-035 The bench SHALL cover: HREADY=0 during ADDR for 2 cycles -> HADDR, HWRITE and HTRANS are stable, and changing request inputs has no effect.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ahb_pkg
// Brief  : Shared AHB-Lite transfer encodings and bus FSM state type.
// Rev    : 1.0  initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } bus_state_t;

    // Requester bit positions in the request/grant vectors
    localparam int unsigned c_REQ_FETCH = 0;
    localparam int unsigned c_REQ_DATA  = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin arbiter; bit 0 = fetch, bit 1 = data.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arb2
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    // Index of the requester granted most recently (0 = fetch)
    logic r_last;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b0;
        end else if (update && (grant != 2'b00)) begin
            r_last <= grant[c_REQ_DATA];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_master_arb.sv
`default_nettype none
// ============================================================================
// Module : ahb_master_arb
// Brief  : Fetch/data request arbiter driving a single non-pipelined AHB-Lite master.
// Rev    : 1.0  initial release
// ============================================================================
module ahb_master_arb
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_req_ready,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_rdata,
    output logic              f_rsp_err,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_write,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_rdata,
    output logic              d_rsp_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              bus_busy
);

    bus_state_t        r_state;
    bus_state_t        w_state_nxt;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_idle;
    logic              w_accept;
    logic [1:0]        r_gnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;

    assign w_req    = {d_req_valid, f_req_valid};
    // Reset gates the combinational ready so nothing is accepted while held in reset
    assign w_idle   = (r_state == ST_IDLE) && rst;
    assign w_accept = w_idle && (w_grant != 2'b00);

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_req),
        .update (w_accept),
        .grant  (w_grant)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt   <= 2'b00;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_gnt   <= w_grant;
            r_addr  <= w_grant[c_REQ_DATA] ? d_req_addr : f_req_addr;
            r_write <= w_grant[c_REQ_DATA] & d_req_write;
            r_wdata <= w_grant[c_REQ_DATA] ? d_req_wdata : '0;
        end
    end

    assign HADDR    = r_addr;
    assign bus_busy = (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        HTRANS      = HTRANS_IDLE;
        HWRITE      = 1'b0;
        HWDATA      = '0;
        f_req_ready = 1'b0;
        d_req_ready = 1'b0;
        f_rsp_valid = 1'b0;
        f_rsp_rdata = '0;
        f_rsp_err   = 1'b0;
        d_rsp_valid = 1'b0;
        d_rsp_rdata = '0;
        d_rsp_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                f_req_ready = w_accept & w_grant[c_REQ_FETCH];
                d_req_ready = w_accept & w_grant[c_REQ_DATA];
                if (w_accept) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = r_write;
                if (HREADY) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                HWDATA = r_write ? r_wdata : '0;
                if (HREADY) begin
                    w_state_nxt = ST_IDLE;
                    f_rsp_valid = r_gnt[c_REQ_FETCH];
                    f_rsp_rdata = (r_gnt[c_REQ_FETCH] && !r_write) ? HRDATA : '0;
                    f_rsp_err   = r_gnt[c_REQ_FETCH] & HRESP;
                    d_rsp_valid = r_gnt[c_REQ_DATA];
                    d_rsp_rdata = (r_gnt[c_REQ_DATA] && !r_write) ? HRDATA : '0;
                    d_rsp_err   = r_gnt[c_REQ_DATA] & HRESP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_ahb_master_arb
// Brief  : Directed self-checking bench for ahb_master_arb.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ahb_master_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req_valid;
    logic [31:0] f_req_addr;
    logic        f_req_ready;
    logic        f_rsp_valid;
    logic [31:0] f_rsp_rdata;
    logic        f_rsp_err;
    logic        d_req_valid;
    logic [31:0] d_req_addr;
    logic        d_req_write;
    logic [31:0] d_req_wdata;
    logic        d_req_ready;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        d_rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        bus_busy;

    int checks = 0;
    int errors = 0;

    ahb_master_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_req_valid (f_req_valid),
        .f_req_addr  (f_req_addr),
        .f_req_ready (f_req_ready),
        .f_rsp_valid (f_rsp_valid),
        .f_rsp_rdata (f_rsp_rdata),
        .f_rsp_err   (f_rsp_err),
        .d_req_valid (d_req_valid),
        .d_req_addr  (d_req_addr),
        .d_req_write (d_req_write),
        .d_req_wdata (d_req_wdata),
        .d_req_ready (d_req_ready),
        .d_rsp_valid (d_rsp_valid),
        .d_rsp_rdata (d_rsp_rdata),
        .d_rsp_err   (d_rsp_err),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .bus_busy    (bus_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        f_req_valid = 1'b1; f_req_addr = 32'h10;
        d_req_valid = 1'b1; d_req_addr = 32'h20; d_req_write = 1'b1; d_req_wdata = 32'h1;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        #3;
        checks++;
        if (HTRANS !== 2'b00) begin errors++; $display("FAIL reset_htrans: got %b expected 00", HTRANS); end
        checks++;
        if (HADDR !== 32'h0 || HWDATA !== 32'h0) begin errors++; $display("FAIL reset_bus: got HADDR=%h HWDATA=%h expected 0/0", HADDR, HWDATA); end
        checks++;
        if ({f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid, bus_busy, HWRITE} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                {f_req_ready, d_req_ready, f_rsp_valid, d_rsp_valid, bus_busy, HWRITE});
        end
        f_req_valid = 1'b0; d_req_valid = 1'b0; d_req_write = 1'b0;
        cyc; cyc;
        rst = 1'b1;
        cyc;
    endtask

    task automatic test_write;
        d_req_valid = 1'b1; d_req_addr = 32'h100; d_req_write = 1'b1; d_req_wdata = 32'hDEADBEEF; HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || HTRANS !== 2'b00) begin errors++; $display("FAIL wr_grant: got ready=%b htrans=%b expected 1/00", d_req_ready, HTRANS); end
        cyc; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({HTRANS, HWRITE} !== 3'b101 || HADDR !== 32'h100) begin
            errors++; $display("FAIL wr_addr: got htrans=%b hwrite=%b haddr=%h expected 10/1/100", HTRANS, HWRITE, HADDR);
        end
        cyc;
        @(negedge clk);
        checks++;
        if (HWDATA !== 32'hDEADBEEF || HTRANS !== 2'b00) begin errors++; $display("FAIL wr_data: got hwdata=%h htrans=%b expected deadbeef/00", HWDATA, HTRANS); end
        checks++;
        if ({d_rsp_valid, d_rsp_err, f_rsp_valid} !== 3'b100 || d_rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL wr_rsp: got v/e/fv=%b rdata=%h expected 100/0", {d_rsp_valid, d_rsp_err, f_rsp_valid}, d_rsp_rdata);
        end
        cyc;
        @(negedge clk);
        checks++;
        if ({d_rsp_valid, bus_busy} !== 2'b00) begin errors++; $display("FAIL wr_end: got rsp/busy=%b expected 00", {d_rsp_valid, bus_busy}); end
        cyc;
    endtask

    task automatic test_read_wait;
        int pulses;
        pulses = 0;
        f_req_valid = 1'b1; f_req_addr = 32'h40; HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (f_req_ready !== 1'b1) begin errors++; $display("FAIL rd_grant: got %b expected 1", f_req_ready); end
        cyc; f_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({HTRANS, HWRITE} !== 3'b100 || HADDR !== 32'h40) begin
            errors++; $display("FAIL rd_addr: got htrans=%b hwrite=%b haddr=%h expected 10/0/40", HTRANS, HWRITE, HADDR);
        end
        cyc; HREADY = 1'b0; HRDATA = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (f_rsp_valid === 1'b1) pulses++;
            cyc;
        end
        checks++;
        if (pulses !== 0) begin errors++; $display("FAIL rd_wait: got %0d early responses expected 0", pulses); end
        HREADY = 1'b1; HRDATA = 32'h00000013;
        @(negedge clk);
        checks++;
        if (f_rsp_valid !== 1'b1 || f_rsp_rdata !== 32'h13 || f_rsp_err !== 1'b0) begin
            errors++; $display("FAIL rd_rsp: got v=%b rdata=%h err=%b expected 1/13/0", f_rsp_valid, f_rsp_rdata, f_rsp_err);
        end
        cyc;
        @(negedge clk);
        checks++;
        if ({f_rsp_valid, bus_busy} !== 2'b00) begin errors++; $display("FAIL rd_end: got rsp/busy=%b expected 00", {f_rsp_valid, bus_busy}); end
        cyc;
    endtask

    task automatic test_round_robin;
        int got [4];
        int exp_order [4];
        int n;
        exp_order = '{1, 0, 1, 0};
        n = 0;
        rst = 1'b0;
        cyc; cyc;
        rst = 1'b1;
        f_req_valid = 1'b1; f_req_addr = 32'h300;
        d_req_valid = 1'b1; d_req_addr = 32'h200; d_req_write = 1'b0;
        HREADY = 1'b1;
        for (int i = 0; i < 20 && n < 4; i++) begin
            @(negedge clk);
            if (d_req_ready === 1'b1) begin got[n] = 1; n++; end
            else if (f_req_ready === 1'b1) begin got[n] = 0; n++; end
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d grants expected 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got[i] !== exp_order[i]) begin errors++; $display("FAIL rr_order%0d: got %0d expected %0d (1=data)", i, got[i], exp_order[i]); end
        end
        cyc; f_req_valid = 1'b0; d_req_valid = 1'b0;
        cyc; cyc;
    endtask

    task automatic test_error;
        d_req_valid = 1'b1; d_req_addr = 32'h80; d_req_write = 1'b0; HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1) begin errors++; $display("FAIL err_grant: got %b expected 1", d_req_ready); end
        cyc; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b10) begin errors++; $display("FAIL err_addr: got %b expected 10", HTRANS); end
        cyc; HREADY = 1'b0; HRESP = 1'b1;
        @(negedge clk);
        checks++;
        if ({HTRANS, d_rsp_valid} !== 3'b000) begin errors++; $display("FAIL err_first: got htrans/rsp=%b expected 000", {HTRANS, d_rsp_valid}); end
        cyc; HREADY = 1'b1; HRDATA = 32'h1234;
        @(negedge clk);
        checks++;
        if ({d_rsp_valid, d_rsp_err, HTRANS} !== 4'b1100) begin
            errors++; $display("FAIL err_second: got v/e/htrans=%b expected 1100", {d_rsp_valid, d_rsp_err, HTRANS});
        end
        cyc; HRESP = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_rsp_valid, bus_busy} !== 2'b00) begin errors++; $display("FAIL err_end: got rsp/busy=%b expected 00", {d_rsp_valid, bus_busy}); end
        cyc;
    endtask

    task automatic test_reset_mid;
        f_req_valid = 1'b1; f_req_addr = 32'h44; HREADY = 1'b1;
        cyc; f_req_valid = 1'b0;
        cyc; HREADY = 1'b0;
        #1;
        rst = 1'b0; HREADY = 1'b1;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'h0 || bus_busy !== 1'b0 || f_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset: got htrans=%b haddr=%h busy=%b rsp=%b expected 00/0/0/0", HTRANS, HADDR, bus_busy, f_rsp_valid);
        end
        cyc; cyc;
        rst = 1'b1;
        d_req_valid = 1'b1; d_req_addr = 32'h120; d_req_write = 1'b1; d_req_wdata = 32'hA5;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1 || f_rsp_valid !== 1'b0) begin errors++; $display("FAIL post_rst_grant: got ready=%b frsp=%b expected 1/0", d_req_ready, f_rsp_valid); end
        cyc; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({HTRANS, HWRITE} !== 3'b101 || HADDR !== 32'h120) begin
            errors++; $display("FAIL post_rst_addr: got htrans=%b hwrite=%b haddr=%h expected 10/1/120", HTRANS, HWRITE, HADDR);
        end
        cyc;
        @(negedge clk);
        checks++;
        if ({d_rsp_valid, f_rsp_valid} !== 2'b10 || HWDATA !== 32'hA5) begin
            errors++; $display("FAIL post_rst_rsp: got drsp/frsp=%b hwdata=%h expected 10/a5", {d_rsp_valid, f_rsp_valid}, HWDATA);
        end
        cyc;
    endtask

    task automatic test_addr_hold;
        d_req_valid = 1'b1; d_req_addr = 32'h180; d_req_write = 1'b1; d_req_wdata = 32'h55; HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (d_req_ready !== 1'b1) begin errors++; $display("FAIL hold_grant: got %b expected 1", d_req_ready); end
        cyc;
        HREADY = 1'b0;
        d_req_addr = 32'h999; d_req_write = 1'b0; d_req_wdata = 32'h77;
        f_req_valid = 1'b1; f_req_addr = 32'h500;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({HTRANS, HWRITE} !== 3'b101 || HADDR !== 32'h180 || {f_req_ready, d_req_ready} !== 2'b00) begin
                errors++; $display("FAIL hold_wait%0d: got htrans=%b hwrite=%b haddr=%h rdy=%b expected 10/1/180/00",
                    i, HTRANS, HWRITE, HADDR, {f_req_ready, d_req_ready});
            end
            cyc;
        end
        HREADY = 1'b1;
        @(negedge clk);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h180) begin errors++; $display("FAIL hold_release: got htrans=%b haddr=%h expected 10/180", HTRANS, HADDR); end
        cyc; f_req_valid = 1'b0; d_req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (HWDATA !== 32'h55 || d_rsp_valid !== 1'b1) begin errors++; $display("FAIL hold_data: got hwdata=%h rsp=%b expected 55/1", HWDATA, d_rsp_valid); end
        cyc;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_round_robin();
        test_error();
        test_reset_mid();
        test_addr_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
